// File: rtl/tick_prescaler_burst_if.sv
// Bus bundle for tick_prescaler_burst: control/config inputs and tick/status outputs.
interface tick_prescaler_burst_if #(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 8
);
  logic                 start;
  logic                 stop;
  logic [DIV_WIDTH-1:0] div;
  logic [CNT_WIDTH-1:0] burst_len;
  logic                 tick;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] tick_count;

  modport master (
    output start, stop, div, burst_len,
    input  tick, busy, done, tick_count
  );

  modport slave (
    input  start, stop, div, burst_len,
    output tick, busy, done, tick_count
  );
endinterface

// File: rtl/tick_prescaler_burst.sv
// Prescaled tick generator issuing bursts of burst_len ticks every div+1 cycles.
// Define TICK_PRESCALER_AUTORELOAD_EN to restart the burst automatically after each done pulse.
module tick_prescaler_burst #(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  tick_prescaler_burst_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           r_state;
  logic [DIV_WIDTH-1:0] r_div_q;
  logic [DIV_WIDTH-1:0] r_pre;
  logic [CNT_WIDTH-1:0] r_len_q;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_tick;
  logic                 r_busy;
  logic                 r_done;

  logic [1:0]           w_state_next;
  logic [DIV_WIDTH-1:0] w_div_next;
  logic [DIV_WIDTH-1:0] w_pre_next;
  logic [CNT_WIDTH-1:0] w_len_next;
  logic [CNT_WIDTH-1:0] w_count_next;
  logic                 w_tick_next;
  logic                 w_pre_hit;
  logic                 w_burst_end;

  assign w_pre_hit   = (r_pre == r_div_q);
  // Count equals length only once the final tick has already been issued.
  assign w_burst_end = (r_len_q != '0) && (r_count == r_len_q);

  always_comb begin
    w_state_next = r_state;
    w_div_next   = r_div_q;
    w_pre_next   = r_pre;
    w_len_next   = r_len_q;
    w_count_next = r_count;
    w_tick_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          w_div_next   = bus.div;
          w_len_next   = bus.burst_len;
          w_pre_next   = '0;
          w_count_next = '0;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          w_state_next = ST_IDLE;
        end else if (w_burst_end) begin
          w_state_next = ST_DONE;
        end else if (w_pre_hit) begin
          w_tick_next  = 1'b1;
          w_pre_next   = '0;
          w_count_next = r_count + CNT_WIDTH'(1);
        end else begin
          w_pre_next   = r_pre + DIV_WIDTH'(1);
        end
      end
      ST_DONE: begin
`ifdef TICK_PRESCALER_AUTORELOAD_EN
        if (bus.stop) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_RUN;
          w_pre_next   = '0;
          w_count_next = '0;
        end
`else
        w_state_next = ST_IDLE;
`endif
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_div_q <= '0;
      r_pre   <= '0;
      r_len_q <= '0;
      r_count <= '0;
      r_tick  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_div_q <= w_div_next;
      r_pre   <= w_pre_next;
      r_len_q <= w_len_next;
      r_count <= w_count_next;
      r_tick  <= w_tick_next;
      r_busy  <= (w_state_next == ST_RUN);
      r_done  <= (w_state_next == ST_DONE);
    end
  end

  assign bus.tick       = r_tick;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.tick_count = r_count;
endmodule
